imem_fetch: RTL
===============

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter ADDR_W, default 8: byte-address width; storage is 2**ADDR_W bytes.
REQ-002 Parameter WAIT_STATES, default 0, legal 0..15: extra cycles between request acceptance and response.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  1  fetch request present.
REQ-006 req_ready  out  1  block can accept a fetch request.
REQ-007 req_addr  in  ADDR_W  byte address of instruction word.
REQ-008 rsp_valid  out  1  response word available.
REQ-009 rsp_ready  in  1  consumer accepts response.
REQ-010 rsp_data  out  32  fetched instruction, little-endian.
REQ-011 rsp_fault  out  1  request address misaligned.
REQ-012 ld_en  in  1  program-load write strobe.
REQ-013 ld_addr  in  ADDR_W  load byte address; bits [1:0] ignored.
REQ-014 ld_data  in  32  load word, little-endian.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Request accepted when req_valid and req_ready high on a rising edge; req_addr captured then.
REQ-017 On acceptance: WAIT_STATES==0 -> RESP next cycle; else WAIT with counter loaded to WAIT_STATES.
REQ-018 In WAIT, counter decrements each cycle; at counter==1 next state RESP; total accept-to-rsp_valid latency WAIT_STATES+1 cycles.
REQ-019 rsp_data SHALL be {mem[a+3],mem[a+2],mem[a+1],mem[a]}, a = captured address, byte-index arithmetic modulo 2**ADDR_W.
REQ-020 Read sampled on the edge entering RESP, using contents before any load write on that same edge (read-before-write).
REQ-021 In RESP, rsp_valid, rsp_data, rsp_fault SHALL hold stable until rsp_ready high; on that edge go IDLE, rsp_valid low next cycle.
REQ-022 No back-to-back acceptance: a new request is accepted only in IDLE, at the earliest the cycle after handshake.
REQ-023 Captured addr[1:0] != 0 -> rsp_fault=1 and rsp_data=32'h00000013 (NOP), with same latency as a normal fetch.
REQ-024 ld_en high on an edge writes ld_data to word {ld_addr[ADDR_W-1:2],2'b00} in any FSM state.
REQ-025 Load to the word of an in-flight request in WAIT SHALL be visible in its response; load on the RESP-entry edge SHALL NOT be.
REQ-026 req_valid in WAIT/RESP is ignored; requester holds it until req_ready.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter 0, rsp_valid 0, rsp_data 0, rsp_fault 0.
REQ-028 Reset mid-WAIT or mid-RESP SHALL discard the in-flight response with no later rsp_valid.
REQ-029 Reset SHALL NOT alter memory contents; power-up contents all zero.

Configuration
REQ-030 Macro IMEM_LOAD_PORT_EN defined: load port per REQ-024/025.
REQ-031 IMEM_LOAD_PORT_EN undefined: ld_en, ld_addr, ld_data ignored; memory read-only after initialisation.

Structure
REQ-032 Package imem_pkg SHALL hold FSM state enum, NOP constant 32'h00000013, WORD_W=32.
REQ-033 Storage SHALL be sub-module imem_bank: byte array, one word write port, one word read port.

Verification
REQ-034 WAIT_STATES=0, load 0x00A00093 at 0x00, fetch 0x00 -> rsp_valid 1 cycle later, rsp_data 0x00A00093, fault 0.
REQ-035 WAIT_STATES=3, fetch 0x04 -> rsp_valid exactly 4 cycles after acceptance; rsp_ready low 5 cycles -> data held constant.
REQ-036 Fetch 0x06 -> rsp_fault 1, rsp_data 0x00000013.
REQ-037 WAIT_STATES=3, fetch 0x08 (old 0x0), load 0x12345678 to 0x08 during WAIT -> rsp_data 0x12345678.
REQ-038 rst_n low during WAIT -> rsp_valid stays 0, req_ready 1 after release, memory word 0x00 unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch block and its storage bank.
package imem_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/imem_bank.sv
// Byte-organised instruction storage: one word write port, one combinational
// little-endian word read port with byte-index wrap-around. Powers up all zero.
module imem_bank
    import imem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-3:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH] = '{default: 8'h00};

    logic [ADDR_W-1:0] ra1, ra2, ra3;

    // Byte indices wrap modulo the storage size.
    assign ra1 = raddr + ADDR_W'(1);
    assign ra2 = raddr + ADDR_W'(2);
    assign ra3 = raddr + ADDR_W'(3);

    assign rdata = {mem[ra3], mem[ra2], mem[ra1], mem[raddr]};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                mem[{waddr, 2'(b)}] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch front-end with fixed wait-state latency and a valid/ready
// response. Define IMEM_LOAD_PORT_EN to enable the program-load write port.
module imem_fetch
    import imem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output state_t            dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; once raised, rsp_valid and its payload hold until rsp_ready.

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] rsp_data_q;
    logic              rsp_fault_q;
    logic              load_rsp;

    logic              bank_we;
    logic [ADDR_W-3:0] bank_waddr;
    logic [WORD_W-1:0] bank_wdata;
    logic              unused_ld;

`ifdef IMEM_LOAD_PORT_EN
    assign bank_we    = ld_en;
    assign bank_waddr = ld_addr[ADDR_W-1:2];
    assign bank_wdata = ld_data;
    assign unused_ld  = ^ld_addr[1:0];
`else
    assign bank_we    = 1'b0;
    assign bank_waddr = '0;
    assign bank_wdata = '0;
    assign unused_ld  = ^{ld_en, ld_addr, ld_data};
`endif

    // With zero wait states the read happens on the accepting edge, before
    // the address has been registered.
    assign rd_addr = (state_q == IDLE) ? req_addr : addr_q;

    imem_bank #(
        .ADDR_W(ADDR_W)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        load_rsp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (WAIT_STATES == 0) begin
                        state_d  = RESP;
                        load_rsp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = RESP;
                    load_rsp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            // Sampled before any same-edge load lands in the bank.
            if (load_rsp) begin
                rsp_fault_q <= is_misaligned(rd_addr[1:0]);
                rsp_data_q  <= is_misaligned(rd_addr[1:0]) ? NOP : rd_word;
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_fault = rsp_fault_q;
    assign dbg_state = state_q;

endmodule
